// File: rtl/window3_feeder.sv
// Sliding 3-sample window feeder with a single registered output triple and valid/ready flow control.
// Optional WINDOW3_PAD_EN: replicate the first samples so every accepted sample emits one triple.
module window3_feeder #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [W-1:0]     out_c,
  output logic [CNT_W-1:0] win_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HAS1  = 2'd1,
    HAS2  = 2'd2,
    FULL  = 2'd3
  } fill_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fill_e            state_q, state_d;
  logic [W-1:0]     s1_q, s1_d;
  logic [W-1:0]     s2_q, s2_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     c_q, c_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             acc;
  logic             fire;
  logic             emit;
  logic [W-1:0]     new_a;
  logic [W-1:0]     new_b;

  // Single output register: a new triple may load in the same cycle the old one leaves.
  assign in_ready = !valid_q | out_ready;
  assign acc      = in_valid & in_ready;
  assign fire     = valid_q & out_ready;

  always_comb begin
    new_a = s2_q;
    new_b = s1_q;
`ifdef WINDOW3_PAD_EN
    emit = 1'b1;
    if (state_q == EMPTY) begin
      new_a = in_data;
      new_b = in_data;
    end else if (state_q == HAS1) begin
      new_a = s1_q;
      new_b = s1_q;
    end
`else
    emit = (state_q == HAS2) || (state_q == FULL);
`endif
  end

  // clear beats acc, but a fire in the same cycle still counts.
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (fire) begin
      valid_d = 1'b0;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    if (clear) begin
      state_d = EMPTY;
      valid_d = 1'b0;
    end else if (acc) begin
      s2_d = s1_q;
      s1_d = in_data;
      case (state_q)
        EMPTY:   state_d = HAS1;
        HAS1:    state_d = HAS2;
        default: state_d = FULL;
      endcase
      if (emit) begin
        a_d     = new_a;
        b_d     = new_b;
        c_d     = in_data;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      s1_q    <= '0;
      s2_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign win_count = cnt_q;

endmodule

// File: tb/tb_window3_feeder.sv
// Self-checking bench for window3_feeder: directed literal checks plus random traffic
// compared every cycle against a stream-history model.
module tb_window3_feeder;

  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_a;
  logic [W-1:0]     out_b;
  logic [W-1:0]     out_c;
  logic [CNT_W-1:0] win_count;

  int errors = 0;
  int checks = 0;

  window3_feeder #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .win_count(win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the window is simply the last samples accepted since reset/clear.
  logic [W-1:0] hist[$];
  bit           armed = 0;
  bit           expValid;
  logic [W-1:0] expA, expB, expC;
  int           expCount;

  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1;
      hist.delete();
      expValid = 0;
      expA = '0; expB = '0; expC = '0;
      expCount = 0;
    end else if (armed) begin
      bit acc, fire;
      acc  = in_valid && (!expValid || out_ready);
      fire = expValid && out_ready;
      if (fire) begin
        expValid = 0;
        if (expCount < MAXC) expCount++;
      end
      if (clear) begin
        hist.delete();
        expValid = 0;
      end else if (acc) begin
        hist.push_back(in_data);
        if (hist.size() > 3) void'(hist.pop_front());
        if (hist.size() == 3) begin
          expA = hist[0]; expB = hist[1]; expC = hist[2]; expValid = 1;
        end
`ifdef WINDOW3_PAD_EN
        else if (hist.size() == 1) begin
          expA = hist[0]; expB = hist[0]; expC = hist[0]; expValid = 1;
        end else begin
          expA = hist[0]; expB = hist[0]; expC = hist[1]; expValid = 1;
        end
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("m_out_valid", int'(out_valid), int'(expValid));
      checkOutput("m_in_ready", int'(in_ready), int'(!expValid || out_ready));
      checkOutput("m_out_a", int'(out_a), int'(expA));
      checkOutput("m_out_b", int'(out_b), int'(expB));
      checkOutput("m_out_c", int'(out_c), int'(expC));
      checkOutput("m_win_count", int'(win_count), expCount);
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge that sampled them.
  task automatic applyStimulus(input bit v, input int d, input bit ordy, input bit clr, input bit rn);
    in_valid  = v;
    in_data   = W'(d);
    out_ready = ordy;
    clear     = clr;
    rst_n     = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int d);
    applyStimulus(1'b1, d, 1'b1, 1'b0, 1'b1);
  endtask

  int padded;

  initial begin
`ifdef WINDOW3_PAD_EN
    padded = 1;
`else
    padded = 0;
`endif
    in_valid = 0; in_data = '0; out_ready = 0; clear = 0; rst_n = 0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_win_count", int'(win_count), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_a", int'(out_a), 0);

    // Basic stream 3,7,1,9
    feed(3); feed(7); feed(1);
    checkOutput("basic_valid1", int'(out_valid), 1);
    checkOutput("basic_a1", int'(out_a), 3);
    checkOutput("basic_b1", int'(out_b), 7);
    checkOutput("basic_c1", int'(out_c), 1);
    feed(9);
    checkOutput("basic_a2", int'(out_a), 7);
    checkOutput("basic_c2", int'(out_c), 9);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("basic_count", int'(win_count), padded ? 4 : 2);
    checkOutput("basic_drained", int'(out_valid), 0);

    // Backpressure
    applyStimulus(0, 0, 1, 1, 1);
    feed(3); feed(7); feed(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 9, 0, 0, 1);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      checkOutput("bp_a", int'(out_a), 3);
      checkOutput("bp_c", int'(out_c), 1);
    end
    applyStimulus(1, 9, 1, 0, 1);
    checkOutput("bp_after_a", int'(out_a), 7);
    checkOutput("bp_after_b", int'(out_b), 1);
    checkOutput("bp_after_c", int'(out_c), 9);

    // Back-to-back fire+load over 0..15
    applyStimulus(0, 0, 1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      feed(i);
      if (i >= 2 || padded == 1) begin
        checkOutput("b2b_valid", int'(out_valid), 1);
        checkOutput("b2b_c", i, int'(out_c));
      end
    end

    // clear with a concurrent accept
    applyStimulus(0, 0, 1, 1, 1);
    feed(5); feed(6);
    applyStimulus(1, 2, 1, 1, 1);
    checkOutput("clr_valid", int'(out_valid), 0);
    feed(4); feed(8); feed(15);
    checkOutput("clr_a", int'(out_a), 4);
    checkOutput("clr_b", int'(out_b), 8);
    checkOutput("clr_c", int'(out_c), 15);

    // Reset while a triple is stalled
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 11, 0, 0, 0);
    checkOutput("mrst_valid", int'(out_valid), 0);
    checkOutput("mrst_a", int'(out_a), 0);
    checkOutput("mrst_c", int'(out_c), 0);
    checkOutput("mrst_count", int'(win_count), 0);
    feed(2);
    checkOutput("mrst_first", int'(out_valid), padded);
    feed(3); feed(4);
    checkOutput("mrst_third_c", int'(out_c), 4);

    // Random traffic
    for (int i = 0; i < 1200; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 199) != 0));
    end

    // Saturation of the window counter
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, i % 16, 1, 0, 1);
    end
    checkOutput("sat_count", int'(win_count), MAXC);
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("sat_hold", int'(win_count), MAXC);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window3_feeder.md
Name: window3_feeder

Overview:
- Streaming front end for the three-input Max/Min/Mid comparator stage.
- Accepts one W-bit sample per handshake and keeps a 3-deep sliding window.
- Presents each complete window as a registered triple (out_a, out_b, out_c) with valid/ready flow control, so a comparator stage can sit directly downstream.

Parameters:
- W, 4, sample width; out_a/out_b/out_c are W bits.
- CNT_W, 8, width of the emitted-window counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low. Sampled only on the clk rising edge.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  W  sample value.
- clear  input  1  synchronous flush of the window; active-high.
- out_valid  output  1  triple on out_a/out_b/out_c is valid.
- out_ready  input  1  downstream accepts the triple.
- out_a  output  W  oldest sample of the window.
- out_b  output  W  middle sample.
- out_c  output  W  newest sample.
- win_count  output  CNT_W  number of triples accepted downstream; saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - fill state = EMPTY; window registers s1, s2 = 0.
  - out_valid = 0; out_a = out_b = out_c = 0; win_count = 0.
  - in_ready is combinational and therefore 1 while out_valid = 0.
- Handshake definitions:
  - Input accept (acc) = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - in_ready = !out_valid | out_ready. This is a single output register: a new window may load in the same cycle the old one fires.
- Fill FSM (counts samples held):
  - EMPTY -acc-> HAS1 -acc-> HAS2 -acc-> FULL. FULL stays FULL on acc.
  - On acc: s2 <= s1; s1 <= in_data.
- Window emission: an acc while in HAS2 or FULL loads the output register in the same edge:
  - out_a <= s2, out_b <= s1, out_c <= in_data, out_valid <= 1.
  - Latency: triple visible the cycle after the third (or later) sample is accepted.
- Hold: while out_valid=1 and out_ready=0:
  - out_a/out_b/out_c are held stable; in_ready = 0.
  - in_data is ignored even if in_valid=1.
- Fire without a new load: out_valid <= 0 next cycle; data outputs keep their last values.
- Fire and load in the same cycle: out_valid stays 1 and the triple updates; no bubble.
- win_count: increments by 1 on each fire and saturates at 2^CNT_W-1; no wrap.
- clear=1 at an edge:
  - FSM -> EMPTY; out_valid <= 0.
  - An acc in the same cycle is discarded: clear has priority over acc.
  - A fire in the same cycle still counts in win_count.
  - s1/s2 need not be zeroed.
  - win_count is not cleared; only rst_n clears it.
- Reset mid-stream: rst_n dominates clear and every handshake; all state returns to reset values on that edge.
- Comparisons are unsigned and W-bit downstream; this block does no arithmetic on data, only ordering.

Optional Feature:
- Macro: WINDOW3_PAD_EN.
- Defined: edge replication at stream start.
  - acc in EMPTY emits (x,x,x) for sample x.
  - acc in HAS1 emits (s1,s1,y) for sample y.
  - From HAS2 onward, behaviour is as described in Behaviour.
  - Every accepted sample therefore yields exactly one triple.
  - After clear, padding restarts from EMPTY.
- Not defined: no output until the third sample after reset/clear; N samples produce N-2 triples.

Test Plan:
- Reset then stream 3,7,1,9 with out_ready=1 always:
  - triples (3,7,1) then (7,1,9), each one cycle after its last accept; win_count=2.
  - With WINDOW3_PAD_EN: (3,3,3), (3,3,7), (3,7,1), (7,1,9); win_count=4.
- Backpressure: after (3,7,1) becomes valid, hold out_ready=0 for 4 cycles with in_valid=1, in_data=9:
  - in_ready=0 and outputs stay (3,7,1).
  - Raise out_ready: (3,7,1) fires, 9 is accepted, (7,1,9) appears next cycle.
- Simultaneous fire+load: continuous in_valid=1 and out_ready=1 over samples 0..15:
  - 14 back-to-back triples; out_valid stays 1 with no gaps after the first.
- clear with concurrent acc: feed 5,6; in the cycle that asserts clear, present in_valid=1 with in_data=2:
  - 2 is dropped and the FSM is EMPTY.
  - Feed 4,8,15: first triple is (4,8,15).
- win_count saturation with CNT_W=2: produce 5 fires; win_count reads 3 after the third fire and stays 3.
- rst_n=0 asserted while out_valid=1 and out_ready=0:
  - Next cycle out_valid=0, outputs=0, win_count=0.
  - The next triple needs 3 fresh samples (1 with WINDOW3_PAD_EN).
